// File: rtl/spi_pkg.sv
// Shared SPI definitions: peripheral FSM state encoding and bus mode constants
// common to the controller and the peripheral.
package spi_pkg;

  typedef logic [1:0] spi_periph_state_e;

  localparam spi_periph_state_e WAIT_IDLE = 2'd0;
  localparam spi_periph_state_e IDLE      = 2'd1;
  localparam spi_periph_state_e ACTIVE    = 2'd2;

  localparam bit CPOL      = 1'b0;
  localparam bit CPHA      = 1'b0;
  localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_peripheral_if.sv
// Bus bundle between an SPI peripheral endpoint and the logic around it
// (SPI pins plus the parallel word side).
interface spi_peripheral_if #(
  parameter int unsigned FRAME_WIDTH = 32
);

  logic                   spi_sclk_i;
  logic                   spi_mosi_i;
  logic                   spi_cs_i;
  logic                   spi_miso_o;
  logic                   spi_miso_oe_o;
  logic [FRAME_WIDTH-1:0] data_i;
  logic [FRAME_WIDTH-1:0] data_o;
  logic                   valid_o;
  logic                   error_o;
  logic                   is_selected_o;

  modport slave (
    input  spi_sclk_i, spi_mosi_i, spi_cs_i, data_i,
    output spi_miso_o, spi_miso_oe_o, data_o, valid_o, error_o, is_selected_o
  );

  modport master (
    output spi_sclk_i, spi_mosi_i, spi_cs_i, data_i,
    input  spi_miso_o, spi_miso_oe_o, data_o, valid_o, error_o, is_selected_o
  );

endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous input bit, with a
// configurable reset level.
module bit_synchronizer #(
  parameter int unsigned STAGES      = 2,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= {STAGES{RESET_VALUE}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 target endpoint, MSB first, fixed frame length. SPI pins are
// oversampled in the clk_i domain; each good frame yields one valid_o strobe.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic             clk_i,
  input logic             reset_i,
  spi_peripheral_if.slave bus
);

  localparam int unsigned CW = $clog2(FRAME_WIDTH + 2);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_hist_q, cs_hist_q;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  spi_periph_state_e      state_q, state_d;
  logic [FRAME_WIDTH-1:0] tx_q, tx_d;
  logic [FRAME_WIDTH-1:0] rx_q, rx_d;
  logic [FRAME_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic                   error_q, error_d;
  logic [SYNC_STAGES:0]   settle_q, settle_d;

  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sclk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (bus.spi_sclk_i),
    .q_o     (sclk_s)
  );

  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (bus.spi_cs_i),
    .q_o     (cs_s)
  );

  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (bus.spi_mosi_i),
    .q_o     (mosi_s)
  );

  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;

  // The cs synchronizer holds its reset level for a while after reset, so
  // WAIT_IDLE only trusts cs_s once the chain has flushed real input through.
  assign settle_d = {settle_q[SYNC_STAGES-1:0], 1'b1};

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (settle_q[SYNC_STAGES] && cs_s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (cs_fall) begin
          tx_d    = bus.data_i;
          cnt_d   = '0;
          rx_d    = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          if (cnt_q == CW'(FRAME_WIDTH)) begin
            data_d  = rx_q;
            valid_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end else begin
          if (sclk_rise) begin
            rx_d = {rx_q[FRAME_WIDTH-2:0], mosi_s};
            if (cnt_q != CW'(FRAME_WIDTH + 1)) begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          if (sclk_fall && (cnt_q != '0) && (cnt_q < CW'(FRAME_WIDTH))) begin
            tx_d = {tx_q[FRAME_WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
      settle_q    <= '0;
      state_q     <= WAIT_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      sclk_hist_q <= sclk_s;
      cs_hist_q   <= cs_s;
      settle_q    <= settle_d;
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
    end
  end

  assign bus.spi_miso_o    = (state_q == ACTIVE) & tx_q[FRAME_WIDTH-1];
  assign bus.spi_miso_oe_o = (state_q == ACTIVE);
  assign bus.is_selected_o = (state_q == ACTIVE);
  assign bus.data_o        = data_q;
  assign bus.valid_o       = valid_q;
  assign bus.error_o       = error_q;

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

SPI target (peripheral) endpoint, mode 0 (CPOL 0, CPHA 0), MSB first, fixed frame length. It is the counterpart of our SPI controller and lets the FPGA act as the device on a bus driven by an external or on-chip controller. SCLK, /CS and MOSI are oversampled in the clk_i domain. Each complete frame delivers the received word with a one-cycle strobe. The word to return on MISO is sampled from data_i at frame start.

## Interface
- FRAME_WIDTH, 32, bits per transfer; must be ≥ 2.
- SYNC_STAGES, 2, synchronizer flops per SPI input; must be ≥ 2.

- clk_i  in  1  system clock; also oversamples the SPI inputs.
- reset_i  in  1  asynchronous, active-high reset.
- spi_sclk_i  in  1  SCLK from the controller; idles low.
- spi_mosi_i  in  1  MOSI.
- spi_cs_i  in  1  /CS, active low.
- spi_miso_o  out  1  MISO data.
- spi_miso_oe_o  out  1  MISO output enable, 1 while selected.
- data_i  in  FRAME_WIDTH  word to transmit; sampled at frame start.
- data_o  out  FRAME_WIDTH  last correctly received word.
- valid_o  out  1  one-cycle pulse: data_o updated.
- error_o  out  1  one-cycle pulse: frame ended with wrong bit count.
- is_selected_o  out  1  1 while in ACTIVE.

## Operation
- Input conditioning:
  - spi_sclk_i, spi_cs_i and spi_mosi_i each pass through SYNC_STAGES flops, then one edge-history flop.
  - Synchronizer reset levels: sclk 0, cs 1, mosi 0.
- Edge events, evaluated on synchronized signals: sclk_rise, sclk_fall, cs_fall, cs_rise.
- States: WAIT_IDLE, IDLE, ACTIVE.
  - **WAIT_IDLE** (reset state): go to IDLE once synchronized cs = 1. A frame already in progress at reset release is ignored.
  - **IDLE**: on cs_fall:
    - tx_shift ← data_i; bit_count ← 0; rx_shift ← 0.
    - Go to ACTIVE.
  - **ACTIVE**:
    - On sclk_rise: rx_shift ← {rx_shift[FRAME_WIDTH-2:0], mosi_sync}; bit_count increments, saturating at FRAME_WIDTH+1.
    - On sclk_fall, when 1 ≤ bit_count < FRAME_WIDTH: tx_shift shifts left by one, zero-filled.
    - On cs_rise: go to IDLE.
      - If bit_count == FRAME_WIDTH: data_o ← rx_shift, valid_o pulses.
      - Otherwise: error_o pulses and data_o holds.
    - sclk events in the same cycle as cs_rise are ignored.
- spi_miso_o = tx_shift[FRAME_WIDTH-1] while in ACTIVE, otherwise 0. spi_miso_oe_o = is_selected_o = (state == ACTIVE).
- SCLK edges seen outside ACTIVE are ignored.
- bit_count width is $clog2(FRAME_WIDTH+2).

## Timing
- Reset values: spi_miso_o 0, spi_miso_oe_o 0, data_o 0, valid_o 0, error_o 0, is_selected_o 0.
- Input-to-event latency is SYNC_STAGES+1 clk_i cycles. State and shift registers update on the following edge.
- MISO:
  - First bit (data_i MSB) is driven SYNC_STAGES+2 cycles after /CS falls.
  - Each later bit is driven SYNC_STAGES+2 cycles after the SCLK falling edge.
- MOSI is taken from the same synchronizer depth as SCLK, so it is the value present at the SCLK rising edge.
- Bus requirements, with S = SYNC_STAGES:
  - SCLK high ≥ S+1 cycles and SCLK low ≥ S+1 cycles.
  - /CS low to first SCLK rise ≥ S+1 cycles.
  - /CS high between frames ≥ S+1 cycles.
- With S = 2, our controller at CLOCK_DIVIDE ≥ 2 (phases of CLOCK_DIVIDE+1 cycles) satisfies all of these.
- valid_o / error_o assert SYNC_STAGES+2 cycles after /CS rises and last exactly one cycle.
- An asynchronous reset mid-frame aborts the frame: no valid_o, no error_o, state goes to WAIT_IDLE.

## Structure
- Shared package spi_pkg holds:
  - the state enum spi_periph_state_e (WAIT_IDLE, IDLE, ACTIVE);
  - the mode constants (CPOL=0, CPHA=0, MSB_FIRST=1) shared with the controller.
- Sub-module bit_synchronizer (parameters STAGES, RESET_VALUE) is instantiated three times, once per SPI input.
- Edge detection, FSM and shift registers live in spi_peripheral.

## Test plan
- **Loopback**: controller (FRAME_WIDTH=32, CLOCK_DIVIDE=2) sends 0xA5A5_0F0F while peripheral data_i = 0x1234_5678.
  - Peripheral: data_o = 0xA5A5_0F0F, one valid_o pulse.
  - Controller: data_o = 0x1234_5678.
- **Back-to-back frames**: 0xFFFF_FFFF then 0x0000_0001, with data_i changed between frames.
  - Two valid_o pulses with the correct words.
  - MISO reflects the data_i value sampled at each /CS fall.
- **Short frame**: /CS released after 17 SCLK rises → error_o pulses once, data_o keeps its previous value.
- **Long frame**: 33 SCLK rises before /CS rises → error_o pulses, no valid_o.
- **Reset handling**:
  - reset_i asserted at bit 10 of a frame, released while /CS is still low → no valid_o or error_o; the next full frame is received correctly.
  - All outputs are 0 during reset.
- **Idle bus**: SCLK toggling with /CS high → no valid_o or error_o, spi_miso_oe_o stays 0.
